timer_cmd_sender: RTL

TIMER_CMD_SENDER -- requirements
Module: timer_cmd_sender

---
 rtl/timer_cmd_sender.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/timer_cmd_sender.sv
// Timer command sender: serialises an 8-bit frame (1101 sync + 4-bit delay, MSB first),
// then waits for the far-end done level and acknowledges it. Optional abort: TIMER_CMD_TIMEOUT_EN.
module timer_cmd_sender #(
   parameter int TIMEOUT_CYCLES = 20000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] delay,
   input  logic       done,
   output logic       ready,
   output logic       data,
   output logic       busy,
   output logic       ack,
   output logic       timeout
);

   typedef enum logic [2:0] {
      IDLE,
      SYNC,
      DELAY,
      WAIT_DONE,
      ACK
`ifdef TIMER_CMD_TIMEOUT_EN
      , TMO
`endif
   } state_t;

   // Sync word sent LSB-indexed by the bit counter: cnt 0..3 -> 1,1,0,1
   localparam logic [3:0] SYNC_PAT = 4'b1011;

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_param_check
      $error("timer_cmd_sender: TIMEOUT_CYCLES must be in 2..65535");
   end

   state_t     state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic [3:0] dly_q, dly_d;
   logic       ready_q, ready_d;
   logic       data_q, data_d;
   logic       busy_q, busy_d;
   logic       ack_q, ack_d;

`ifdef TIMER_CMD_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] tmo_cnt_q, tmo_cnt_d;
   logic        timeout_q, timeout_d;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dly_d   = dly_q;
`ifdef TIMER_CMD_TIMEOUT_EN
      tmo_cnt_d = tmo_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               dly_d   = delay;
               cnt_d   = 2'd0;
               state_d = SYNC;
            end
         end
         SYNC: begin
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) state_d = DELAY;
         end
         DELAY: begin
            cnt_d = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
               state_d = WAIT_DONE;
`ifdef TIMER_CMD_TIMEOUT_EN
               tmo_cnt_d = 16'd0;
`endif
            end
         end
         WAIT_DONE: begin
            // done beats the terminal count when both occur together
            if (done) state_d = ACK;
`ifdef TIMER_CMD_TIMEOUT_EN
            else if (tmo_cnt_q == TMO_LAST) state_d = TMO;
            else tmo_cnt_d = tmo_cnt_q + 16'd1;
`endif
         end
         ACK:     state_d = IDLE;
`ifdef TIMER_CMD_TIMEOUT_EN
         TMO:     state_d = IDLE;
`endif
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they describe
   always_comb begin
      data_d = 1'b0;
      case (state_d)
         SYNC:    data_d = SYNC_PAT[cnt_d];
         DELAY:   data_d = dly_d[2'd3 - cnt_d];
         default: data_d = 1'b0;
      endcase
      ready_d = (state_d == IDLE);
      busy_d  = (state_d == SYNC) || (state_d == DELAY) || (state_d == WAIT_DONE);
      ack_d   = (state_d == ACK);
`ifdef TIMER_CMD_TIMEOUT_EN
      timeout_d = (state_d == TMO);
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         dly_q   <= 4'd0;
         ready_q <= 1'b1;
         data_q  <= 1'b0;
         busy_q  <= 1'b0;
         ack_q   <= 1'b0;
`ifdef TIMER_CMD_TIMEOUT_EN
         tmo_cnt_q <= 16'd0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dly_q   <= dly_d;
         ready_q <= ready_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         ack_q   <= ack_d;
`ifdef TIMER_CMD_TIMEOUT_EN
         tmo_cnt_q <= tmo_cnt_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   assign ready = ready_q;
   assign data  = data_q;
   assign busy  = busy_q;
   assign ack   = ack_q;
`ifdef TIMER_CMD_TIMEOUT_EN
   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

endmodule
